// File: rtl/pipe_exec_pkg.sv
// Shared definitions for the pipeline execution sequencer: state encoding,
// debug command codes and the opcodes the controller reacts to.
package pipe_exec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear; holds at all ones
// instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        cnt_q <= cnt_d;
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_exec_ctrl.sv
// Execution sequencer for the 5-stage MIPS pipeline: debug RUN/STEP/STOP,
// HALT drain and enabled-cycle count. Define PIPE_EXEC_BREAKPOINT_EN for the PC breakpoint.
module pipe_exec_ctrl
    import pipe_exec_pkg::*;
#(
    parameter int                 INSBITS      = 6,
    parameter int                 PCBITS       = 32,
    parameter int                 CNTBITS      = 32,
    parameter int                 DRAIN_CYCLES = 4,
    parameter logic [INSBITS-1:0] HALT_OPCODE  = INSBITS'(pipe_exec_pkg::HALT_OPCODE)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    input  logic [1:0]         i_cmd,
    output logic               o_cmd_ready,
    input  logic [INSBITS-1:0] i_if_opcode,
    input  logic [PCBITS-1:0]  i_if_pc,
`ifdef PIPE_EXEC_BREAKPOINT_EN
    input  logic               i_bp_valid,
    input  logic [PCBITS-1:0]  i_bp_addr,
`endif
    output logic               o_pipe_en,
    output logic               o_if_bubble,
    output logic               o_halted,
    output logic               o_done,
    output logic [CNTBITS-1:0] o_cycle_cnt
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_e        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          done_q, done_d;
    logic          cmd_acc;
    logic          halt_seen;
    logic          bp_hit;

    assign o_cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_HALTED);
    assign cmd_acc     = i_cmd_valid && o_cmd_ready;
    assign halt_seen   = (i_if_opcode == HALT_OPCODE);

`ifdef PIPE_EXEC_BREAKPOINT_EN
    logic skip_q, skip_d;

    // Skip lets a resume from the breakpoint PC execute that instruction once.
    assign bp_hit = (state_q == ST_RUN) && i_bp_valid && (i_if_pc == i_bp_addr) && !skip_q;

    always_comb begin
        skip_d = skip_q;
        if ((state_q == ST_IDLE) && cmd_acc && ((i_cmd == CMD_RUN) || (i_cmd == CMD_STEP))) begin
            skip_d = 1'b1;
        end else if (o_pipe_en) begin
            skip_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            skip_q <= 1'b0;
        end else begin
            skip_q <= skip_d;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^i_if_pc;
    assign bp_hit    = 1'b0;
`endif

    assign o_pipe_en   = ((state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN)) && !bp_hit;
    assign o_if_bubble = (state_q == ST_DRAIN);
    assign o_halted    = (state_q == ST_HALTED);
    assign o_done      = done_q;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    case (i_cmd)
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                // Breakpoint outranks HALT: the instruction at IF never executes.
                if (bp_hit) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (halt_seen) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(DRAIN_CYCLES);
                end else if (cmd_acc && (i_cmd == CMD_STOP)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (halt_seen) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(DRAIN_CYCLES);
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - DW'(1);
                if (drain_q <= DW'(1)) begin
                    state_d = ST_HALTED;
                    done_d  = 1'b1;
                end
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    sat_counter #(
        .WIDTH (CNTBITS)
    ) u_cycle_cnt (
        .i_clk (i_clk),
        .i_clr (i_reset),
        .i_en  (o_pipe_en),
        .o_cnt (o_cycle_cnt)
    );

endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// Bench for pipe_exec_ctrl: directed scenarios plus random commands/opcodes,
// checked every cycle against a mode-level model; a 4-bit-counter instance covers saturation.
module tb_pipe_exec_ctrl;

    localparam logic [5:0] HALT = 6'b111111;
    localparam int         DRAIN_N = 4;
    localparam logic [1:0] C_NOP = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_STOP = 2'b11;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALTED = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic [5:0]  op  = 6'd0;
    logic [31:0] pc  = 32'd0;

    logic        rdy, pen, bub, hlt, done;
    logic [31:0] cnt;
    logic        rdy4, pen4, bub4, hlt4, done4;
    logic [3:0]  cnt4;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     m_mode  = M_IDLE;
    int     m_left  = 0;
    bit     m_done  = 1'b0;
    longint m_cnt   = 0;

    always #5 clk = ~clk;

    pipe_exec_ctrl dut (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(vld), .i_cmd(cmd), .o_cmd_ready(rdy),
        .i_if_opcode(op), .i_if_pc(pc), .o_pipe_en(pen), .o_if_bubble(bub),
        .o_halted(hlt), .o_done(done), .o_cycle_cnt(cnt)
    );

    pipe_exec_ctrl #(.CNTBITS(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(vld), .i_cmd(cmd), .o_cmd_ready(rdy4),
        .i_if_opcode(op), .i_if_pc(pc), .o_pipe_en(pen4), .o_if_bubble(bub4),
        .o_halted(hlt4), .o_done(done4), .o_cycle_cnt(cnt4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the mode-level model by one clock using the inputs the DUT sampled.
    task automatic model_update();
        bit en, acc;
        if (rst) begin
            m_mode = M_IDLE; m_left = 0; m_done = 1'b0; m_cnt = 0;
        end else begin
            en  = (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
            acc = vld && ((m_mode == M_IDLE) || (m_mode == M_RUN) || (m_mode == M_HALTED));
            if (en) m_cnt++;
            m_done = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (acc && cmd == C_RUN) m_mode = M_RUN;
                    else if (acc && cmd == C_STEP) m_mode = M_STEP;
                end
                M_RUN: begin
                    if (op == HALT) begin m_mode = M_DRAIN; m_left = DRAIN_N; end
                    else if (acc && cmd == C_STOP) m_mode = M_IDLE;
                end
                M_STEP: begin
                    if (op == HALT) begin m_mode = M_DRAIN; m_left = DRAIN_N; end
                    else begin m_mode = M_IDLE; m_done = 1'b1; end
                end
                M_DRAIN: begin
                    m_left--;
                    if (m_left == 0) begin m_mode = M_HALTED; m_done = 1'b1; end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        bit     e_en, e_rdy;
        longint e_c4;
        e_en  = (m_mode == M_RUN) || (m_mode == M_STEP) || (m_mode == M_DRAIN);
        e_rdy = (m_mode == M_IDLE) || (m_mode == M_RUN) || (m_mode == M_HALTED);
        e_c4  = (m_cnt > 15) ? 15 : m_cnt;
        check("pipe_en", 64'(pen), 64'(e_en));
        check("cmd_ready", 64'(rdy), 64'(e_rdy));
        check("if_bubble", 64'(bub), 64'(m_mode == M_DRAIN));
        check("halted", 64'(hlt), 64'(m_mode == M_HALTED));
        check("done", 64'(done), 64'(m_done));
        check("cycle_cnt", 64'(cnt), 64'(m_cnt));
        check("pipe_en_w4", 64'(pen4), 64'(e_en));
        check("cmd_ready_w4", 64'(rdy4), 64'(e_rdy));
        check("if_bubble_w4", 64'(bub4), 64'(m_mode == M_DRAIN));
        check("halted_w4", 64'(hlt4), 64'(m_mode == M_HALTED));
        check("done_w4", 64'(done4), 64'(m_done));
        check("cycle_cnt_w4", 64'(cnt4), 64'(e_c4));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic cyc(input logic r, input logic v, input logic [1:0] c, input logic [5:0] o);
        rst = r; vld = v; cmd = c; op = o;
        tick();
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, C_NOP, 6'd0);
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_ready", 64'(rdy), 64'd1);
        check("rst_pipe_en", 64'(pen), 64'd0);
        check("rst_cnt", 64'(cnt), 64'd0);

        // RUN, HALT at enabled cycle 10, 4 drain cycles
        cyc(1'b0, 1'b1, C_RUN, 6'd0);
        repeat (9) cyc(1'b0, 1'b0, C_NOP, 6'd0);
        cyc(1'b0, 1'b0, C_NOP, HALT);
        check("halt_bubble", 64'(bub), 64'd1);
        repeat (4) cyc(1'b0, 1'b0, C_NOP, 6'd0);
        check("halt_halted", 64'(hlt), 64'd1);
        check("halt_done", 64'(done), 64'd1);
        check("halt_cnt", 64'(cnt), 64'd14);
        cyc(1'b0, 1'b1, C_RUN, 6'd0);
        check("halted_done_once", 64'(done), 64'd0);
        check("halted_sticks", 64'(hlt), 64'd1);

        // Three single steps
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, C_STEP, 6'd0);
            check("step_ready_low", 64'(rdy), 64'd0);
            cyc(1'b0, 1'b0, C_NOP, 6'd0);
            check("step_done", 64'(done), 64'd1);
            cyc(1'b0, 1'b0, C_NOP, 6'd0);
        end
        check("step_cnt", 64'(cnt), 64'd3);

        // RUN, STOP on the 5th cycle, resume
        do_reset();
        cyc(1'b0, 1'b1, C_RUN, 6'd0);
        repeat (4) cyc(1'b0, 1'b0, C_NOP, 6'd0);
        cyc(1'b0, 1'b1, C_STOP, 6'd0);
        check("stop_pipe_en", 64'(pen), 64'd0);
        check("stop_bubble", 64'(bub), 64'd0);
        check("stop_cnt", 64'(cnt), 64'd5);
        cyc(1'b0, 1'b1, C_RUN, 6'd0);
        repeat (3) cyc(1'b0, 1'b0, C_NOP, 6'd0);
        check("resume_cnt", 64'(cnt), 64'd8);

        // HALT and STOP together, command held during drain
        do_reset();
        cyc(1'b0, 1'b1, C_RUN, 6'd0);
        repeat (2) cyc(1'b0, 1'b0, C_NOP, 6'd0);
        cyc(1'b0, 1'b1, C_STOP, HALT);
        check("halt_wins", 64'(bub), 64'd1);
        repeat (4) cyc(1'b0, 1'b1, C_STOP, 6'd0);
        check("drain_ignores_cmd", 64'(hlt), 64'd1);
        check("halt_stop_cnt", 64'(cnt), 64'd7);

        // Reset in the second drain cycle
        do_reset();
        cyc(1'b0, 1'b1, C_RUN, 6'd0);
        cyc(1'b0, 1'b0, C_NOP, HALT);
        cyc(1'b0, 1'b0, C_NOP, 6'd0);
        cyc(1'b1, 1'b0, C_NOP, 6'd0);
        check("midrst_bubble", 64'(bub), 64'd0);
        check("midrst_pipe_en", 64'(pen), 64'd0);
        check("midrst_cnt", 64'(cnt), 64'd0);
        check("midrst_ready", 64'(rdy), 64'd1);

        // 20-cycle run: 4-bit counter saturates
        cyc(1'b0, 1'b1, C_RUN, 6'd0);
        repeat (20) cyc(1'b0, 1'b0, C_NOP, 6'd0);
        check("sat_cnt_w4", 64'(cnt4), 64'd15);
        check("sat_cnt_w32", 64'(cnt), 64'd20);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            pc = $urandom;
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 1) == 1),
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 15) == 0) ? HALT : 6'($urandom_range(0, 62)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_exec_ctrl.md
Name: pipe_exec_ctrl

Overview:
- Execution sequencer for the 5-stage MIPS pipeline.
- Accepts RUN/STEP/STOP commands from the debug unit over a valid/ready handshake.
- Gates the global pipeline enable and detects the HALT opcode in IF, then drains the in-flight instructions before freezing.
- Keeps a saturating count of executed cycles for debug readout.

Parameters:
- INSBITS, 6, opcode width.
- PCBITS, 32, PC width.
- CNTBITS, 32, cycle counter width.
- DRAIN_CYCLES, 4, enabled cycles needed after HALT is fetched to retire ID..WB.
- HALT_OPCODE, 6'b111111, opcode that halts execution.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command valid.
- i_cmd  in  2  command code: 00 NOP, 01 RUN, 10 STEP, 11 STOP.
- o_cmd_ready  out  1  controller can accept a command.
- i_if_opcode  in  INSBITS  opcode of the instruction currently at IF.
- i_if_pc  in  PCBITS  PC of the instruction at IF; used only with the optional feature.
- o_pipe_en  out  1  enable for the PC and all pipeline latches.
- o_if_bubble  out  1  hold the PC and inject a NOP into IF/ID.
- o_halted  out  1  high in HALTED.
- o_done  out  1  one-cycle pulse when a step ends, HALTED is entered, or a breakpoint hits.
- o_cycle_cnt  out  CNTBITS  number of cycles with o_pipe_en=1.

Behaviour:
- Interface: one clock i_clk; reset i_reset is synchronous and active-high and overrides every other input.
- Reset values: state IDLE, o_pipe_en=0, o_if_bubble=0, o_halted=0, o_done=0, o_cycle_cnt=0, drain counter 0. o_cmd_ready=1 from the first cycle after reset.
- States: IDLE, RUN, STEP, DRAIN, HALTED. All outputs are Moore, decoded from the state register, except the breakpoint gating described under Optional Feature.
- o_pipe_en=1 in RUN, STEP and DRAIN.
- o_cmd_ready=1 in IDLE, RUN and HALTED; 0 in STEP and DRAIN.
- A command is accepted on a clock edge where i_cmd_valid and o_cmd_ready are both 1. Latency: a command accepted at edge N changes o_pipe_en from cycle N+1.
- IDLE:
  - RUN -> RUN.
  - STEP -> STEP.
  - NOP or STOP -> stay in IDLE.
- RUN:
  - i_if_opcode==HALT_OPCODE -> DRAIN, drain counter loaded with DRAIN_CYCLES.
  - Otherwise an accepted STOP -> IDLE, pipeline frozen and not drained.
  - RUN, STEP and NOP are accepted and ignored.
  - If HALT is detected in the same cycle as STOP, HALT wins.
- STEP:
  - Exactly one enabled cycle, then -> IDLE with o_done=1 in the following cycle.
  - If HALT_OPCODE is seen during the step cycle -> DRAIN instead, and no done pulse is issued for the step.
- DRAIN:
  - o_if_bubble=1, so the PC does not advance past HALT.
  - The drain counter decrements each cycle; when it reaches 1 -> HALTED.
  - DRAIN_CYCLES=0 is illegal.
- HALTED:
  - o_pipe_en=0, o_halted=1.
  - o_done pulses for exactly the first cycle.
  - Commands are accepted and ignored; only i_reset leaves this state.
- Counter: o_cycle_cnt increments on each edge where o_pipe_en=1 and saturates at all ones; it never wraps.
- Mid-operation reset (in STEP or DRAIN, for example) returns to IDLE the next cycle with the counter cleared.

Optional Feature:
- Macro: PIPE_EXEC_BREAKPOINT_EN.
- When defined, adds two ports: i_bp_valid (in, 1) and i_bp_addr (in, PCBITS).
- Breakpoint hit: in RUN, i_bp_valid=1 and i_if_pc==i_bp_addr, and the skip flag is clear.
- On a hit, o_pipe_en is forced to 0 combinationally in that same cycle, the state goes to IDLE, and o_done pulses next cycle.
- A skip flag is set on every RUN/STEP acceptance from IDLE and cleared after the first enabled cycle. This lets a resume execute past the breakpoint PC.
- When the macro is undefined, the ports and logic are absent and i_if_pc is unused.

Decomposition:
- Shared package pipe_exec_pkg holds:
  - the state encoding localparams;
  - the command codes CMD_NOP, CMD_RUN, CMD_STEP, CMD_STOP;
  - HALT_OPCODE, next to the opcode macros used by the main controller.
- Sub-module sat_counter (width parameter, enable, synchronous clear) implements o_cycle_cnt and is reusable for the debug unit's other counters.

Test Plan:
- Reset, then RUN; HALT fetched at enabled cycle 10 -> DRAIN for 4 cycles with o_if_bubble=1, then o_halted=1, one o_done pulse, and o_cycle_cnt=14.
- From IDLE, three STEP commands -> each gives exactly one o_pipe_en cycle and one o_done pulse; o_cycle_cnt=3; o_cmd_ready=0 only during the step cycles.
- RUN, then STOP after 5 cycles -> IDLE with o_pipe_en=0 and no drain; a new RUN resumes and the counter continues from 5.
- HALT opcode and STOP in the same cycle -> DRAIN is taken; i_cmd_valid held high during DRAIN is not accepted.
- i_reset asserted in the second DRAIN cycle -> next cycle IDLE, all outputs at reset values; CNTBITS=4 with a 20-cycle run -> count saturates at 15.
- With PIPE_EXEC_BREAKPOINT_EN, i_bp_addr=0x20 -> o_pipe_en drops in the cycle i_if_pc=0x20 and o_done pulses; RUN again -> execution passes 0x20 without stopping.
